// File: rtl/arm_datapath_core_if.sv
// Control/datapath bundle between the control unit and the integer datapath core.
// The control unit drives the selects, opcode and strobes. The core drives the
// register reads, the shifter and ALU results, and the flags.
interface arm_datapath_core_if;
  logic [31:0] Pcin;
  logic [19:0] RSLCT;
  logic        LOADPC;
  logic        LOAD;
  logic        IR_CU;
  logic [31:0] IR;
  logic [4:0]  OP;
  logic        S;
  logic        ALU_OUT;
  logic [31:0] Rn;
  logic [31:0] Rm;
  logic [31:0] Rs;
  logic [31:0] PCout;
  logic [31:0] SHIFT_OUT;
  logic [31:0] ALU_RESULT;
  logic [3:0]  FLAGS;

  modport master (
    output Pcin, RSLCT, LOADPC, LOAD, IR_CU, IR, OP, S, ALU_OUT,
    input  Rn, Rm, Rs, PCout, SHIFT_OUT, ALU_RESULT, FLAGS
  );

  modport slave (
    input  Pcin, RSLCT, LOADPC, LOAD, IR_CU, IR, OP, S, ALU_OUT,
    output Rn, Rm, Rs, PCout, SHIFT_OUT, ALU_RESULT, FLAGS
  );
endinterface

// File: rtl/arm_datapath_core.sv
// Integer datapath of the ARM-subset CPU: 16x32 register file (R15 = PC),
// operand-2 barrel shifter, 5-bit-opcode ALU and registered NZCV flags.
module arm_datapath_core (
  input  logic                 Clk,
  input  logic                 RESET,
  arm_datapath_core_if.slave   dp
);

  logic [31:0] regs [16];
  logic [3:0]  flags;          // {N,Z,C,V}
  logic [31:0] rn_val, rm_val, rs_val;
  logic        c_flag;

  logic [31:0] sh_res;
  logic        sh_c;
  logic [7:0]  sh_amt;
  logic [5:0]  rot;
  logic [32:0] tmp33;

  logic [31:0] add_x, add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic        add_v;
  logic [31:0] alu_res;
  logic        is_arith, is_logic, wr_en;
  logic [3:0]  rd_sel;

  assign rn_val = regs[dp.RSLCT[3:0]];
  assign rm_val = regs[dp.RSLCT[7:4]];
  assign rs_val = regs[dp.RSLCT[11:8]];
  assign c_flag = flags[1];

  assign dp.Rn        = rn_val;
  assign dp.Rm        = rm_val;
  assign dp.Rs        = rs_val;
  assign dp.PCout     = regs[15];
  assign dp.SHIFT_OUT = sh_res;
  assign dp.FLAGS     = flags;
  assign dp.ALU_RESULT = dp.ALU_OUT ? alu_res : 'z;

  // Operand-2 barrel shifter: rotated immediate or shifted Rm, plus shifter carry
  always_comb begin
    sh_res = rm_val;
    sh_c   = c_flag;
    tmp33  = '0;
    rot    = {1'b0, dp.IR[11:8], 1'b0};
    sh_amt = dp.IR[4] ? rs_val[7:0] : {3'b000, dp.IR[11:7]};
    if (dp.IR[25]) begin
      sh_res = ({24'b0, dp.IR[7:0]} >> rot) | ({24'b0, dp.IR[7:0]} << (6'd32 - rot));
      sh_c   = (rot != 6'd0) ? sh_res[31] : c_flag;
    end else if (sh_amt == 8'd0) begin
      // Immediate amount 0 encodes LSR/ASR #32 and RRX; register amount 0 is a no-op
      if (!dp.IR[4]) begin
        case (dp.IR[6:5])
          2'b01:   begin sh_res = '0;                 sh_c = rm_val[31]; end
          2'b10:   begin sh_res = {32{rm_val[31]}};   sh_c = rm_val[31]; end
          2'b11:   begin sh_res = {c_flag, rm_val[31:1]}; sh_c = rm_val[0]; end
          default: begin sh_res = rm_val;             sh_c = c_flag;     end
        endcase
      end
    end else begin
      case (dp.IR[6:5])
        2'b00: begin
          if (sh_amt < 8'd32) begin
            tmp33  = {1'b0, rm_val} << sh_amt[4:0];
            sh_res = tmp33[31:0];
            sh_c   = tmp33[32];
          end else begin
            sh_res = '0;
            sh_c   = (sh_amt == 8'd32) ? rm_val[0] : 1'b0;
          end
        end
        2'b01: begin
          if (sh_amt < 8'd32) begin
            tmp33  = {rm_val, 1'b0} >> sh_amt[4:0];
            sh_res = tmp33[32:1];
            sh_c   = tmp33[0];
          end else begin
            sh_res = '0;
            sh_c   = (sh_amt == 8'd32) ? rm_val[31] : 1'b0;
          end
        end
        2'b10: begin
          if (sh_amt < 8'd32) begin
            tmp33  = $signed({rm_val, 1'b0}) >>> sh_amt[4:0];
            sh_res = tmp33[32:1];
            sh_c   = tmp33[0];
          end else begin
            sh_res = {32{rm_val[31]}};
            sh_c   = rm_val[31];
          end
        end
        default: begin
          if (sh_amt[4:0] == 5'd0) begin
            sh_res = rm_val;
            sh_c   = rm_val[31];
          end else begin
            sh_res = (rm_val >> sh_amt[4:0]) | (rm_val << (6'd32 - {1'b0, sh_amt[4:0]}));
            sh_c   = sh_res[31];
          end
        end
      endcase
    end
  end

  // Shared adder operands: subtraction is x + ~y + 1, carry-in ops use the registered C
  always_comb begin
    add_x   = rn_val;
    add_y   = sh_res;
    add_cin = 1'b0;
    case (dp.OP)
      5'd2, 5'd10: begin add_y = ~sh_res; add_cin = 1'b1; end
      5'd3:        begin add_x = sh_res; add_y = ~rn_val; add_cin = 1'b1; end
      5'd5:        add_cin = c_flag;
      5'd6:        begin add_y = ~sh_res; add_cin = c_flag; end
      5'd7:        begin add_x = sh_res; add_y = ~rn_val; add_cin = c_flag; end
      5'd17:       add_y = 32'd4;
      5'd18:       add_y = 32'hFFFF_FFFC;
      default:     ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
  assign add_v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);

  // ALU result select and opcode class for flag handling
  always_comb begin
    alu_res  = '0;
    is_arith = 1'b0;
    is_logic = 1'b0;
    case (dp.OP)
      5'd0, 5'd8:  begin alu_res = rn_val & sh_res;  is_logic = 1'b1; end
      5'd1, 5'd9:  begin alu_res = rn_val ^ sh_res;  is_logic = 1'b1; end
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11:
                   begin alu_res = sum[31:0];        is_arith = 1'b1; end
      5'd12:       begin alu_res = rn_val | sh_res;  is_logic = 1'b1; end
      5'd13:       begin alu_res = sh_res;           is_logic = 1'b1; end
      5'd14:       begin alu_res = rn_val & ~sh_res; is_logic = 1'b1; end
      5'd15:       begin alu_res = ~sh_res;          is_logic = 1'b1; end
      5'd16:       alu_res = rn_val;
      5'd17, 5'd18: alu_res = sum[31:0];
      5'd19:       alu_res = sh_res;
      default:     alu_res = '0;
    endcase
  end

  assign rd_sel = dp.IR_CU ? dp.RSLCT[15:12] : dp.RSLCT[19:16];
  assign wr_en  = dp.LOAD && dp.ALU_OUT && !((dp.OP >= 5'd8) && (dp.OP <= 5'd11));

  // Register write-back; a PC load lands after the ALU write so it wins on R15
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (wr_en) regs[rd_sel] <= alu_res;
      if (dp.LOADPC) regs[15] <= dp.Pcin;
    end
  end

  // NZCV update: arithmetic sets C/V from the adder, logical takes shifter carry
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      flags <= '0;
    end else if (dp.S) begin
      flags[3] <= alu_res[31];
      flags[2] <= (alu_res == 32'd0);
      if (is_arith) begin
        flags[1] <= sum[32];
        flags[0] <= add_v;
      end else if (is_logic) begin
        flags[1] <= sh_c;
      end
    end
  end

endmodule

// File: tb/tb_arm_datapath_core.sv
// Directed bench for arm_datapath_core with a cycle-level reference model.
module tb_arm_datapath_core;
  logic Clk = 1'b0;
  logic RESET;
  arm_datapath_core_if dp();

  arm_datapath_core dut (.Clk(Clk), .RESET(RESET), .dp(dp));

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_reg [16];
  logic [3:0]  m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    logic [31:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  // Returns {carry, operand}
  function automatic logic [32:0] m_shift(input logic [31:0] ir, input logic [31:0] rm,
                                          input logic [31:0] rs, input logic cin);
    int amt;
    logic [31:0] r;
    logic [63:0] w;
    if (ir[25]) begin
      amt = 2 * int'(ir[11:8]);
      r = rotr({24'b0, ir[7:0]}, amt);
      return {(amt != 0) ? r[31] : cin, r};
    end
    amt = ir[4] ? int'(rs[7:0]) : int'(ir[11:7]);
    if (amt == 0) begin
      if (ir[4] || ir[6:5] == 2'b00) return {cin, rm};
      if (ir[6:5] == 2'b11) return {rm[0], cin, rm[31:1]};
      amt = 32;
    end
    case (ir[6:5])
      2'b00: begin w = {32'b0, rm} << amt; return {w[32], w[31:0]}; end
      2'b01: begin w = {rm, 32'b0} >> amt; return {w[31], w[63:32]}; end
      2'b10: begin
        if (amt > 32) amt = 32;
        w = $signed({rm, 32'b0}) >>> amt;
        return {w[31], w[63:32]};
      end
      default: begin
        if (amt % 32 == 0) return {rm[31], rm};
        r = rotr(rm, amt % 32);
        return {r[31], r};
      end
    endcase
  endfunction

  function automatic void m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] f, input logic shc,
                                output logic [31:0] res, output logic [3:0] nf);
    longint ua, ub, sa, sb, u, s, nb;
    int kind;   // 0 logical, 1 arithmetic, 2 N/Z only
    bit sub;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    nb = f[1] ? 0 : 1;
    u = 0; s = 0; sub = 0; kind = 2; res = '0;
    case (op)
      5'd0, 5'd8: begin res = a & b; kind = 0; end
      5'd1, 5'd9: begin res = a ^ b; kind = 0; end
      5'd12: begin res = a | b;  kind = 0; end
      5'd13: begin res = b;      kind = 0; end
      5'd14: begin res = a & ~b; kind = 0; end
      5'd15: begin res = ~b;     kind = 0; end
      5'd2, 5'd10: begin u = ua - ub; s = sa - sb; sub = 1; kind = 1; end
      5'd3: begin u = ub - ua; s = sb - sa; sub = 1; kind = 1; end
      5'd4, 5'd11: begin u = ua + ub; s = sa + sb; kind = 1; end
      5'd5: begin u = ua + ub + (1 - nb); s = sa + sb + (1 - nb); kind = 1; end
      5'd6: begin u = ua - ub - nb; s = sa - sb - nb; sub = 1; kind = 1; end
      5'd7: begin u = ub - ua - nb; s = sb - sa - nb; sub = 1; kind = 1; end
      5'd16: res = a;
      5'd17: res = a + 32'd4;
      5'd18: res = a - 32'd4;
      5'd19: res = b;
      default: res = '0;
    endcase
    if (kind == 1) res = u[31:0];
    nf = f;
    nf[3] = res[31];
    nf[2] = (res == 32'd0);
    if (kind == 1) begin
      nf[1] = sub ? (u >= 0) : (u > 64'sh0000_0000_FFFF_FFFF);
      nf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (kind == 0) begin
      nf[1] = shc;
    end
  endfunction

  // Compare every cycle against the model, then advance the model across the next edge
  always @(negedge Clk) begin
    logic [31:0] a, r;
    logic [32:0] sh;
    logic [3:0]  nf, rd;
    if (RESET) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_flags = '0;
    end
    a  = m_reg[dp.RSLCT[3:0]];
    sh = m_shift(dp.IR, m_reg[dp.RSLCT[7:4]], m_reg[dp.RSLCT[11:8]], m_flags[1]);
    m_alu(dp.OP, a, sh[31:0], m_flags, sh[32], r, nf);
    chk("Rn", dp.Rn, a);
    chk("Rm", dp.Rm, m_reg[dp.RSLCT[7:4]]);
    chk("Rs", dp.Rs, m_reg[dp.RSLCT[11:8]]);
    chk("PCout", dp.PCout, m_reg[15]);
    chk("SHIFT_OUT", dp.SHIFT_OUT, sh[31:0]);
    chk("FLAGS", {28'b0, dp.FLAGS}, {28'b0, m_flags});
    if (dp.ALU_OUT) chk("ALU_RESULT", dp.ALU_RESULT, r);
    if (!RESET) begin
      if (dp.S) m_flags = nf;
      rd = dp.IR_CU ? dp.RSLCT[15:12] : dp.RSLCT[19:16];
      if (dp.LOAD && dp.ALU_OUT && !(dp.OP >= 5'd8 && dp.OP <= 5'd11)) m_reg[rd] = r;
      if (dp.LOADPC) m_reg[15] = dp.Pcin;
    end
  end

  function automatic logic [19:0] sl(input logic [3:0] rd2, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rm,
                                     input logic [3:0] rn);
    return {rd2, rd, rs, rm, rn};
  endfunction

  // ctl = {S, LOAD, IR_CU, ALU_OUT, LOADPC}
  task automatic step(input logic [19:0] sel, input logic [4:0] op, input logic [31:0] ir,
                      input logic [4:0] ctl, input logic [31:0] pcin);
    @(posedge Clk);
    #1;
    dp.RSLCT = sel; dp.OP = op; dp.IR = ir; dp.Pcin = pcin;
    {dp.S, dp.LOAD, dp.IR_CU, dp.ALU_OUT, dp.LOADPC} = ctl;
  endtask

  logic [31:0] sh_ir  [10] = '{32'h20, 32'h40, 32'h60, 32'h80, 32'h260,
                               32'h10, 32'h30, 32'h70, 32'h50, 32'h30};
  logic [3:0]  sh_rs  [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 4'd5, 4'd3, 4'd0};
  logic [31:0] sh_exp [10] = '{32'h0, 32'hFFFF_FFFF, 32'hC000_0000, 32'h2, 32'h1800_0000,
                               32'h0, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    dp.RSLCT = '0; dp.OP = '0; dp.IR = '0; dp.Pcin = '0;
    dp.S = 0; dp.LOAD = 0; dp.IR_CU = 1; dp.ALU_OUT = 1; dp.LOADPC = 0;
    #3;
    chk("reset_Rn", dp.Rn, 32'h0);
    chk("reset_PC", dp.PCout, 32'h0);
    chk("reset_FLAGS", {28'b0, dp.FLAGS}, 32'h0);
    repeat (2) @(posedge Clk);
    #1 RESET = 1'b0;

    step(sl(0, 1, 0, 0, 0), 5'd17, 32'h0, 5'b01110, 32'h0);
    #1 chk("add4_result", dp.ALU_RESULT, 32'h4);
    step(sl(0, 1, 0, 0, 1), 5'd17, 32'h0, 5'b01110, 32'h0);
    #1 chk("r1_is_4", dp.Rn, 32'h4);
    step(sl(0, 2, 0, 1, 1), 5'd4, 32'h10, 5'b11110, 32'h0);
    #1 chk("r1_is_8", dp.Rn, 32'h8);
    chk("add_result", dp.ALU_RESULT, 32'h10);
    step(sl(0, 0, 0, 2, 2), 5'd2, 32'h0, 5'b10110, 32'h0);
    #1 chk("r2_is_16", dp.Rn, 32'h10);
    chk("add_flags", {28'b0, dp.FLAGS}, 32'h0);
    chk("sub_zero", dp.ALU_RESULT, 32'h0);
    step(sl(0, 0, 0, 2, 2), 5'd12, 32'h0, 5'b00110, 32'h0);
    #1 chk("sub_flags", {28'b0, dp.FLAGS}, 32'h6);
    step(sl(0, 3, 0, 0, 0), 5'd13, 32'h0200_01FF, 5'b11110, 32'h0);
    #1 chk("hold_flags", {28'b0, dp.FLAGS}, 32'h6);
    chk("imm_rot", dp.SHIFT_OUT, 32'hC000_003F);
    step(sl(4, 0, 0, 0, 3), 5'd13, 32'h0200_0106, 5'b01010, 32'h0);
    #1 chk("mov_flags", {28'b0, dp.FLAGS}, 32'hA);
    chk("r3_value", dp.Rn, 32'hC000_003F);
    step(sl(0, 5, 0, 0, 4), 5'd13, 32'h0200_0020, 5'b01110, 32'h0);
    #1 chk("alt_rd_r4", dp.Rn, 32'h8000_0001);
    step(sl(0, 6, 0, 0, 0), 5'd13, 32'h0200_0021, 5'b01110, 32'h0);

    for (int i = 0; i < 10; i++) begin
      step(sl(0, 0, sh_rs[i], 4, 0), 5'd13, sh_ir[i], 5'b10110, 32'h0);
      #1 chk($sformatf("shift_%0d", i), dp.SHIFT_OUT, sh_exp[i]);
    end

    for (int op = 0; op < 32; op++) begin
      step(sl(0, 7, 0, 4, 3), 5'(op), 32'h0,
           (op >= 8 && op <= 11) ? 5'b11110 : 5'b10110, 32'h0);
      #1;
      if (op == 2) chk("op2_sub", dp.ALU_RESULT, 32'h4000_003E);
      if (op == 4) chk("op4_add", dp.ALU_RESULT, 32'h4000_0040);
    end
    step(sl(0, 0, 0, 0, 7), 5'd16, 32'h0, 5'b00110, 32'h0);
    #1 chk("cmp_no_write", dp.Rn, 32'h0);

    step(sl(0, 15, 0, 0, 1), 5'd17, 32'h0, 5'b01111, 32'h100);
    step(sl(0, 0, 0, 0, 0), 5'd16, 32'h0, 5'b00110, 32'h0);
    #1 chk("loadpc_prio", dp.PCout, 32'h100);
    step(sl(0, 1, 0, 0, 0), 5'd13, 32'h0200_00FF, 5'b01100, 32'h0);
    step(sl(0, 0, 0, 0, 1), 5'd16, 32'h0, 5'b00110, 32'h0);
    #1 chk("alu_out0_blocked", dp.Rn, 32'h8);

    step(sl(0, 2, 0, 0, 2), 5'd17, 32'h0, 5'b01110, 32'h0);
    #2 RESET = 1'b1;
    #1 chk("midrst_Rn", dp.Rn, 32'h0);
    chk("midrst_PC", dp.PCout, 32'h0);
    chk("midrst_FLAGS", {28'b0, dp.FLAGS}, 32'h0);
    step(sl(0, 2, 0, 0, 2), 5'd17, 32'h0, 5'b01110, 32'h0);
    #1 chk("rst_write_blocked", dp.Rn, 32'h0);
    @(posedge Clk);
    #1 RESET = 1'b0;
    step(sl(0, 0, 0, 0, 2), 5'd16, 32'h0, 5'b00110, 32'h0);
    #1 chk("post_reset_write", dp.Rn, 32'h4);
    step(sl(0, 0, 0, 0, 0), 5'd16, 32'h0, 5'b00110, 32'h0);
    @(posedge Clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
